deserializer_v2: RTL

- Serial-to-parallel receiver for the Arduino link. It is the receive-side counterpart of SerializerV2.
- Accepts an asynchronous serial clock, data and frame-enable from the Arduino, synchronizes them into Clk, and shifts 2*NumbDataBits bits in, MSB first.
- Presents each completed frame as two words, Output1 (first received half) and Output2 (second half), with a Valid/Ack handshake and a sticky overrun flag.

---
 rtl/deserializer_v2_pkg.sv | 13 +
 rtl/deserializer_v2_sync_rise_detect.sv | 30 +++
 rtl/deserializer_v2.sv | 133 +++++++++++++
 3 files changed

// File: rtl/deserializer_v2_pkg.sv
// Shared types and defaults for the Arduino-link serial receiver.
// Holds the receive state encoding and the default synchronizer depth.
// No logic lives here; nothing to backpressure.
package deserializer_v2_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/deserializer_v2_sync_rise_detect.sv
// Synchronizes one asynchronous level into Clk and flags its rising edges.
// Latency: Sync and Rise appear SyncStages+1 Clk edges after the pin is first sampled.
// No backpressure: Rise is a single-cycle strobe that the consumer must take.
module sync_rise_detect #(
    parameter int SyncStages = 2
) (
    input  logic Async,
    input  logic Clk,
    input  logic Clr,
    output logic Sync,
    output logic Rise
);

    logic [SyncStages-1:0] chain;

    // Metastability chain, then a history flop that doubles as the aligned level.
    // Rise is registered from the same edge as Sync so both are high together.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            chain <= '0;
            Sync  <= 1'b0;
            Rise  <= 1'b0;
        end else begin
            chain <= {chain[SyncStages-2:0], Async};
            Sync  <= chain[SyncStages-1];
            Rise  <= chain[SyncStages-1] & ~Sync;
        end
    end

endmodule

// File: rtl/deserializer_v2.sv
// Serial-to-parallel receiver: shifts 2*NumbDataBits bits MSB first and presents two words.
// Latency: outputs update SyncStages+2 Clk edges after the edge that first samples SerialClk=1.
// Valid/Ack handshake; a frame completing while Valid=1 and Ack=0 is dropped and sets Overrun.
module deserializer_v2
    import deserializer_v2_pkg::*;
#(
    parameter int NumbDataBits = 8,
    parameter int SyncStages   = SYNC_STAGES
) (
    input  logic                    Clk,
    input  logic                    Clr,
    input  logic                    SerialClk,
    input  logic                    SerialData,
    input  logic                    FrameEn,
    input  logic                    Ack,
    output logic [NumbDataBits-1:0] Output1,
    output logic [NumbDataBits-1:0] Output2,
    output logic                    Valid,
    output logic                    Overrun,
    output logic                    Busy
);

    localparam int FrameBits = 2 * NumbDataBits;
    localparam int CountW    = $clog2(FrameBits);
    localparam logic [CountW-1:0] LastBit = CountW'(FrameBits - 1);

    logic                 sclk;
    logic                 sclk_rise;
    logic                 edge_stb;
    logic [SyncStages:0]  data_chain;
    logic [SyncStages:0]  fen_chain;
    logic                 sdata;
    logic                 sframe_en;

    state_t               state;
    logic [CountW-1:0]    count;
    logic [FrameBits-1:0] shreg;
    logic [FrameBits-1:0] next_shreg;
    logic [FrameBits-1:0] frame_q;
    logic                 done_q;

    sync_rise_detect #(
        .SyncStages (SyncStages)
    ) u_clk_sync (
        .Async (SerialClk),
        .Clk   (Clk),
        .Clr   (Clr),
        .Sync  (sclk),
        .Rise  (sclk_rise)
    );

    // Data and frame enable get one flop beyond the synchronizer depth so they
    // line up with the clock path, whose edge history adds the same extra stage.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            data_chain <= '0;
            fen_chain  <= '0;
        end else begin
            data_chain <= {data_chain[SyncStages-1:0], SerialData};
            fen_chain  <= {fen_chain[SyncStages-1:0], FrameEn};
        end
    end

    assign sdata      = data_chain[SyncStages];
    assign sframe_en  = fen_chain[SyncStages];
    assign edge_stb   = sclk_rise & sclk;
    assign next_shreg = {shreg[FrameBits-2:0], sdata};
    assign Busy       = (state == ST_RECV) && (count != '0);

    // Receive FSM: collects bits on each serial clock rise, emits a one-cycle
    // completion pulse with the captured frame; losing FrameEn discards the partial frame.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state   <= ST_IDLE;
            count   <= '0;
            shreg   <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    count <= '0;
                    shreg <= '0;
                    if (sframe_en) begin
                        state <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (!sframe_en) begin
                        state <= ST_IDLE;
                        count <= '0;
                        shreg <= '0;
                    end else if (edge_stb) begin
                        shreg <= next_shreg;
                        if (count == LastBit) begin
                            frame_q <= next_shreg;
                            done_q  <= 1'b1;
                            count   <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output handshake: accept a completed frame when the slot is free or being
    // acknowledged in the same cycle; otherwise keep the old frame and flag the loss.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            Output1 <= '0;
            Output2 <= '0;
            Valid   <= 1'b0;
            Overrun <= 1'b0;
        end else if (done_q) begin
            if (!Valid || Ack) begin
                Output1 <= frame_q[FrameBits-1:NumbDataBits];
                Output2 <= frame_q[NumbDataBits-1:0];
                Valid   <= 1'b1;
            end else begin
                Overrun <= 1'b1;
            end
        end else if (Valid && Ack) begin
            Valid <= 1'b0;
        end
    end

endmodule
